// File: rtl/score_disp_pkg.sv
// Shared constants for the score display: segment patterns (active-low,
// bit order dp,g,f,e,d,c,b,a), blanking values and the BCD digit count.
package score_disp_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low anode pattern selecting one digit slot.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/score_display_seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern; non-decimal
// nibbles render as a single dash so a corrupted score is visible.
module seg7_decode
    import score_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Four-digit scan-multiplexed common-anode driver for the BCD game score,
// with per-frame snapshot and game-over blinking. Define SCORE_LZB_EN for
// leading-zero blanking.
module score_display
    import score_disp_pkg::*;
#(
    parameter int SCAN_DIV_W  = 17,
    parameter int BLINK_DIV_W = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score,
    input  logic        game_over,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    logic [SCAN_DIV_W-1:0]  presc_q, presc_d;
    logic [1:0]             idx_q, idx_d;
    logic [15:0]            shadow_q, shadow_d;
    logic [BLINK_DIV_W-1:0] blink_q, blink_d;
    logic [3:0]             an_q, an_d;
    logic [7:0]             seg_q, seg_d;

    logic       tick;
    logic [3:0] nibble;
    logic [7:0] seg_dec;
    logic       digit_blank;
    logic       blink_off;

    assign tick      = &presc_q;
    assign blink_off = game_over & blink_q[BLINK_DIV_W-1];

    always_comb begin
        nibble = shadow_q[3:0];
        case (idx_q)
            2'd1:    nibble = shadow_q[7:4];
            2'd2:    nibble = shadow_q[11:8];
            2'd3:    nibble = shadow_q[15:12];
            default: nibble = shadow_q[3:0];
        endcase
    end

    seg7_decode u_decode (
        .nibble (nibble),
        .seg    (seg_dec)
    );

`ifdef SCORE_LZB_EN
    // A digit is suppressed only if it and every more significant digit are zero.
    always_comb begin
        digit_blank = 1'b0;
        case (idx_q)
            2'd3:    digit_blank = (shadow_q[15:12] == 4'd0);
            2'd2:    digit_blank = (shadow_q[15:8] == 8'd0);
            2'd1:    digit_blank = (shadow_q[15:4] == 12'd0);
            default: digit_blank = 1'b0;
        endcase
    end
`else
    assign digit_blank = 1'b0;
`endif

    always_comb begin
        presc_d  = presc_q + 1'b1;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        blink_d  = game_over ? blink_q + 1'b1 : '0;
        an_d     = an_q;
        seg_d    = seg_q;
        if (tick) begin
            idx_d = idx_q + 1'b1;
            // Snapshot at frame wrap; the slot latched now still uses the old shadow.
            if (idx_q == 2'd3) begin
                shadow_d = score;
            end
            if (blink_off || digit_blank) begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
            end else begin
                an_d  = an_select(idx_q);
                seg_d = seg_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            blink_q  <= '0;
            an_q     <= AN_OFF;
            seg_q    <= SEG_BLANK;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            blink_q  <= blink_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display with a cycle-level behavioural model.
module tb_score_display;

    localparam int SW    = 2;
    localparam int BW    = 5;
    localparam int SLOT  = 1 << SW;
    localparam int HALF  = 1 << (BW - 1);

    logic        clk;
    logic        rst_n;
    logic [15:0] score;
    logic        game_over;
    logic [3:0]  an;
    logic [7:0]  seg;

    int checks;
    int errors;

    score_display #(.SCAN_DIV_W(SW), .BLINK_DIV_W(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .score     (score),
        .game_over (game_over),
        .an        (an),
        .seg       (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dec(input int v);
        case (v)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    // Model state: cycles since reset, frame snapshot, consecutive game_over cycles.
    int         m_cyc;
    int         m_shadow;
    int         m_blink;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc    = 0;
            m_shadow = 0;
            m_blink  = 0;
            exp_an   = 4'hF;
            exp_seg  = 8'hFF;
        end else begin
            if (m_cyc % SLOT == SLOT - 1) begin
                int  dig;
                bit  blank;
                dig   = (m_cyc / SLOT) % 4;
                blank = game_over && ((m_blink / HALF) % 2 == 1);
`ifdef SCORE_LZB_EN
                if (dig > 0 && (m_shadow >> (4 * dig)) == 0) blank = 1'b1;
`endif
                if (blank) begin
                    exp_an  = 4'hF;
                    exp_seg = 8'hFF;
                end else begin
                    exp_an  = 4'(15 - (1 << dig));
                    exp_seg = dec((m_shadow >> (4 * dig)) & 15);
                end
                if (dig == 3) m_shadow = int'(score);
            end
            m_blink = game_over ? m_blink + 1 : 0;
            m_cyc   = m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        checks = checks + 1;
        if (an !== exp_an || seg !== exp_seg) begin
            errors = errors + 1;
            $display("FAIL model_cmp t=%0t an=%h seg=%h expected an=%h seg=%h",
                     $time, an, seg, exp_an, exp_seg);
        end
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s t=%0t got an/seg=%h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] pick_score();
        logic [15:0] s;
        case ($urandom_range(0, 7))
            0: s = 16'h0000;
            1: s = 16'h0199;
            2: s = 16'h0200;
            3: s = 16'h00C0;
            4: s = 16'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9));
            5: s = 16'($urandom_range(0, 65535));
            default: s = 16'(($urandom_range(0, 9) << 12) | ($urandom_range(0, 9) << 8)
                              | ($urandom_range(0, 9) << 4) | $urandom_range(0, 9));
        endcase
        return s;
    endfunction

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        score     = 16'h0000;
        game_over = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        score = 16'h1234;

        // Edges counted from release: first tick at edge 4, snapshot at edge 16.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_first_tick", {an, seg}, 12'hFFF);
        @(posedge clk);
        @(negedge clk);
        chk("first_digit", {an, seg}, {4'hE, 8'hC0});
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("s1234_d0", {an, seg}, {4'hE, 8'h99});
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("s1234_d1", {an, seg}, {4'hD, 8'hB0});
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("s1234_d2", {an, seg}, {4'hB, 8'hA4});
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("s1234_d3", {an, seg}, {4'h7, 8'hF9});

        // Long game_over stretch: visible then blanked half-periods.
        game_over = 1'b1;
        repeat (80) @(negedge clk);
        game_over = 1'b0;
        repeat (20) @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            score = pick_score();
            if ($urandom_range(0, 3) == 0) game_over = ~game_over;
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clk);
                #1 rst_n = 1'b0;
                #1 chk("async_reset", {an, seg}, 12'hFFF);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (SLOT) @(posedge clk);
                @(negedge clk);
                chk("post_reset_shadow0", {an, seg}, {4'hE, 8'hC0});
            end
            repeat ($urandom_range(3, 90)) @(negedge clk);
        end

        game_over = 1'b0;
        repeat (40) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
